control_loop_seq: RTL

Iteration sequencer for the PI control loop: runs one loop iteration per pass and sits directly around `control_loop_math`. Each iteration converts the ADC, arms the math stage with the latched setpoint, measurement, previous error and elapsed cycle count, then folds the returned `adjval` into the held DAC word with saturation. It writes that word to the DAC and waits a programmable delay before the next iteration. Handshakes are level-style arm/finished throughout.

---
 rtl/control_loop_pkg.sv | 21 ++
 rtl/control_loop_seq_sat_add.sv | 23 ++
 rtl/control_loop_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/control_loop_pkg.sv
// Shared widths, state encoding and DAC saturation limits for the PI loop sequencer.
package control_loop_pkg;

    localparam int unsigned CONSTS_WID      = 48;
    localparam int unsigned ADC_WID         = 18;
    localparam int unsigned DAC_DATA_WID    = 20;
    localparam int unsigned CYCLE_COUNT_WID = 18;
    localparam int unsigned DELAY_WID       = 16;

    localparam logic [DAC_DATA_WID-1:0] DAC_MAX = {1'b0, {(DAC_DATA_WID-1){1'b1}}};
    localparam logic [DAC_DATA_WID-1:0] DAC_MIN = {1'b1, {(DAC_DATA_WID-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADC_REQ  = 3'd1,
        ST_MATH_REQ = 3'd2,
        ST_DAC_REQ  = 3'd3,
        ST_DELAY    = 3'd4
    } state_t;

endpackage

// File: rtl/control_loop_seq_sat_add.sv
// Two's-complement adder that clamps the sum to the operand width.
module sat_add #(
    parameter int unsigned       WID     = 20,
    parameter logic [WID-1:0]    SAT_MAX = {1'b0, {(WID-1){1'b1}}},
    parameter logic [WID-1:0]    SAT_MIN = {1'b1, {(WID-1){1'b0}}}
) (
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    output logic [WID-1:0] sum_c
);

    logic [WID:0] full_c;

    // One guard bit; overflow shows as disagreement between the top two bits.
    always_comb begin
        full_c = {a[WID-1], a} + {b[WID-1], b};
        sum_c  = full_c[WID-1:0];
        if (full_c[WID] != full_c[WID-1]) begin
            sum_c = full_c[WID] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/control_loop_seq.sv
// PI loop iteration sequencer: ADC conversion, math stage, saturated DAC update, delay.
module control_loop_seq
    import control_loop_pkg::*;
#(
    parameter int unsigned CYCLE_WID = CYCLE_COUNT_WID
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic [ADC_WID-1:0]      setpt_in,
    input  logic [DELAY_WID-1:0]    dely,
    input  logic [DAC_DATA_WID-1:0] dac_init,
    output logic                    adc_arm,
    input  logic                    adc_finished,
    input  logic [ADC_WID-1:0]      adc_data,
    output logic                    math_arm,
    input  logic                    math_finished,
    output logic [ADC_WID-1:0]      setpt,
    output logic [ADC_WID-1:0]      measured,
    output logic [CONSTS_WID-1:0]   e_prev,
    output logic [CYCLE_WID-1:0]    cycles,
    input  logic [CONSTS_WID-1:0]   e_cur,
    input  logic [DAC_DATA_WID-1:0] adjval,
    output logic                    dac_arm,
    input  logic                    dac_finished,
    output logic [DAC_DATA_WID-1:0] dac_out,
    output logic                    busy
);

    localparam logic [CYCLE_WID-1:0] CNT_MAX = '1;

    state_t                  state;
    logic [CYCLE_WID-1:0]    cnt;
    logic [DELAY_WID-1:0]    dely_q;
    logic [DELAY_WID-1:0]    dly_cnt;
    logic [DAC_DATA_WID-1:0] dac_next_c;

    sat_add #(
        .WID     (DAC_DATA_WID),
        .SAT_MAX (DAC_MAX),
        .SAT_MIN (DAC_MIN)
    ) u_sat_add (
        .a     (dac_out),
        .b     (adjval),
        .sum_c (dac_next_c)
    );

    // Sequencer; each arm rises only while its finished is low and drops once finished is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            adc_arm  <= 1'b0;
            math_arm <= 1'b0;
            dac_arm  <= 1'b0;
            setpt    <= '0;
            measured <= '0;
            e_prev   <= '0;
            cycles   <= '0;
            dac_out  <= '0;
            cnt      <= '0;
            dely_q   <= '0;
            dly_cnt  <= '0;
        end else begin
            if (state != ST_IDLE && cnt != CNT_MAX) begin
                cnt <= cnt + CYCLE_WID'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state   <= ST_ADC_REQ;
                        busy    <= 1'b1;
                        dac_out <= dac_init;
                        e_prev  <= '0;
                        cnt     <= '0;
                        setpt   <= setpt_in;
                        dely_q  <= dely;
                        adc_arm <= ~adc_finished;
                    end
                end
                ST_ADC_REQ: begin
                    if (adc_arm && adc_finished) begin
                        measured <= adc_data;
                        adc_arm  <= 1'b0;
                        state    <= ST_MATH_REQ;
                        if (!math_finished) begin
                            math_arm <= 1'b1;
                            cycles   <= cnt;
                            cnt      <= CYCLE_WID'(1);
                        end
                    end else if (!adc_arm && !adc_finished) begin
                        adc_arm <= 1'b1;
                    end
                end
                ST_MATH_REQ: begin
                    if (math_arm && math_finished) begin
                        e_prev   <= e_cur;
                        dac_out  <= dac_next_c;
                        math_arm <= 1'b0;
                        state    <= ST_DAC_REQ;
                        dac_arm  <= ~dac_finished;
                    end else if (!math_arm && !math_finished) begin
                        math_arm <= 1'b1;
                        cycles   <= cnt;
                        cnt      <= CYCLE_WID'(1);
                    end
                end
                ST_DAC_REQ: begin
                    if (dac_arm && dac_finished) begin
                        dac_arm <= 1'b0;
                        dly_cnt <= dely_q;
                        state   <= ST_DELAY;
                    end else if (!dac_arm && !dac_finished) begin
                        dac_arm <= 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (dly_cnt != '0) begin
                        dly_cnt <= dly_cnt - DELAY_WID'(1);
                    end else if (run) begin
                        state   <= ST_ADC_REQ;
                        setpt   <= setpt_in;
                        dely_q  <= dely;
                        adc_arm <= ~adc_finished;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
